// File: rtl/wave_seq_pkg.sv
// wave_seq_pkg: shared types and constants for the waveform sequencer.
// Holds the FSM state encoding, the generator waveform-select codes and
// the field layout of a packed table entry {sel, freq, dwell}.
package wave_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RUN     = 2'd2,
        ST_WAIT_ZC = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SINE = 2'd0;
    localparam logic [1:0] SEL_COS  = 2'd1;
    localparam logic [1:0] SEL_TRI  = 2'd2;
    localparam logic [1:0] SEL_SQR  = 2'd3;

    // Table entry packing: dwell occupies the low bits, freq above it,
    // the two select bits on top.
    localparam int CFG_SEL_W     = 2;
    localparam int CFG_DWELL_LSB = 0;

    function automatic int cfg_freq_lsb(input int dwell_w);
        return CFG_DWELL_LSB + dwell_w;
    endfunction

    function automatic int cfg_sel_lsb(input int dwell_w, input int freq_w);
        return CFG_DWELL_LSB + dwell_w + freq_w;
    endfunction

endpackage

// File: rtl/wave_seq_zc_det.sv
// wave_seq_zc_det: rising zero-crossing detector on a signed sample stream.
// The previous sample's sign bit is held in a flop; zc is high in the cycle
// where the previous sample was negative and the current one is not.
module wave_seq_zc_det #(
    parameter int width = 12
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [width-1:0] sample,
    output logic             zc
);

    logic prev_msb_r;

    // Sign history; reset treats the previous sample as non-negative.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            prev_msb_r <= 1'b0;
        end else begin
            prev_msb_r <= sample[width-1];
        end
    end

    assign zc = prev_msb_r & ~sample[width-1];

endmodule

// File: rtl/wave_sequencer.sv
// wave_sequencer: replays a small table of {waveform, frequency, dwell}
// entries into the CORDIC generator. Entry changes wait for a rising zero
// crossing of the generator output (or happen at once for a freq=0 entry).
// Optional feature macro: WAVE_SEQ_LOOP_EN -- when defined the sequence
// wraps from the last entry back to entry 0 forever and done never pulses.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int width      = 12,
    parameter int freq_width = 13,
    parameter int DEPTH      = 8,
    parameter int DWELL_W    = 18,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                                 clock,
    input  logic                                 resetn,
    input  logic                                 cfg_we,
    input  logic [AW-1:0]                        cfg_addr,
    input  logic [CFG_SEL_W+freq_width+DWELL_W-1:0] cfg_wdata,
    input  logic [AW-1:0]                        cfg_last,
    input  logic                                 start,
    input  logic                                 stop,
    input  logic [width-1:0]                     sample,
    output logic [freq_width-1:0]                freq,
    output logic [1:0]                           waveform_sel,
    output logic [AW-1:0]                        entry,
    output logic                                 busy,
    output logic                                 done
);

    localparam int DATA_W   = CFG_SEL_W + freq_width + DWELL_W;
    localparam int FREQ_LSB = cfg_freq_lsb(DWELL_W);
    localparam int SEL_LSB  = cfg_sel_lsb(DWELL_W, freq_width);
    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0]     table_r [DEPTH];
    state_t                state_r;
    logic [AW-1:0]         idx_r;
    logic [DWELL_W-1:0]    dwell_r;

    logic                  zc_s;
    logic [DATA_W-1:0]     rd_s;
    logic [DWELL_W-1:0]    rd_dwell_s;
    logic [freq_width-1:0] rd_freq_s;
    logic [1:0]            rd_sel_s;
    logic                  exit_s;
    logic                  last_s;

    wave_seq_zc_det #(.width(width)) u_zc_det (
        .clock  (clock),
        .resetn (resetn),
        .sample (sample),
        .zc     (zc_s)
    );

    assign rd_s       = table_r[idx_r];
    assign rd_dwell_s = rd_s[CFG_DWELL_LSB +: DWELL_W];
    assign rd_freq_s  = rd_s[FREQ_LSB +: freq_width];
    assign rd_sel_s   = rd_s[SEL_LSB +: CFG_SEL_W];

    // A silent entry (freq=0) never crosses zero, so it leaves without one.
    assign exit_s = (freq == {freq_width{1'b0}}) | zc_s;
    assign last_s = (idx_r >= cfg_last);

    // Entry table: one write per cycle in any state; a same-cycle LOAD
    // sees the old word because the read happens before this edge lands.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_r[i] <= {DATA_W{1'b0}};
            end
        end else if (cfg_we) begin
            table_r[cfg_addr] <= cfg_wdata;
        end
    end

    // Sequencer FSM with registered generator-facing outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            idx_r        <= {AW{1'b0}};
            dwell_r      <= {DWELL_W{1'b0}};
            freq         <= {freq_width{1'b0}};
            waveform_sel <= SEL_SINE;
            entry        <= {AW{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state_r      <= ST_IDLE;
                freq         <= {freq_width{1'b0}};
                waveform_sel <= SEL_SINE;
                entry        <= {AW{1'b0}};
                busy         <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            idx_r   <= {AW{1'b0}};
                            busy    <= 1'b1;
                            state_r <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        freq         <= rd_freq_s;
                        waveform_sel <= rd_sel_s;
                        dwell_r      <= (rd_dwell_s == {DWELL_W{1'b0}}) ? DWELL_ONE : rd_dwell_s;
                        entry        <= idx_r;
                        state_r      <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (dwell_r == DWELL_ONE) begin
                            state_r <= ST_WAIT_ZC;
                        end else begin
                            dwell_r <= dwell_r - DWELL_ONE;
                        end
                    end
                    ST_WAIT_ZC: begin
                        if (exit_s) begin
                            if (!last_s) begin
                                idx_r   <= idx_r + {{(AW-1){1'b0}}, 1'b1};
                                state_r <= ST_LOAD;
                            end else begin
`ifdef WAVE_SEQ_LOOP_EN
                                idx_r   <= {AW{1'b0}};
                                state_r <= ST_LOAD;
`else
                                done         <= 1'b1;
                                busy         <= 1'b0;
                                freq         <= {freq_width{1'b0}};
                                waveform_sel <= SEL_SINE;
                                entry        <= {AW{1'b0}};
                                state_r      <= ST_IDLE;
`endif
                            end
                        end
                    end
                    default: begin
                        state_r      <= ST_IDLE;
                        freq         <= {freq_width{1'b0}};
                        waveform_sel <= SEL_SINE;
                        entry        <= {AW{1'b0}};
                        busy         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/wave_sequencer.md
# wave_sequencer

Programmable waveform scheduler that drives the `freq` and `waveform_sel` inputs of the CORDIC waveform generator top level. It replays a small table of {waveform, frequency, dwell} entries. Transitions between entries are deferred to a rising zero crossing of the generator output, so the PWM and VGA paths never see a step discontinuity. It sits between the board-level control inputs and the generator, replacing direct pin-driven `freq` and `waveform_sel`.

## Interface
- `width`, 12: generator sample width (signed).
- `freq_width`, 13: frequency word width.
- `DEPTH`, 8: table entries; power of two.
- `DWELL_W`, 18: dwell counter width in clock cycles.
- `AW`, $clog2(DEPTH): table address width (derived).

Ports:
- `clock`  in  1: sole clock.
- `resetn`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: table write strobe.
- `cfg_addr`  in  AW: table write address.
- `cfg_wdata`  in  2+freq_width+DWELL_W: packed as {sel[1:0], freq, dwell}.
- `cfg_last`  in  AW: index of the last active entry.
- `start`  in  1: level; sampled in IDLE only.
- `stop`  in  1: level; abort.
- `sample`  in  width: current generator output (signed).
- `freq`  out  freq_width: frequency to generator.
- `waveform_sel`  out  2: 0 sine, 1 cosine, 2 triangle, 3 square.
- `entry`  out  AW: index currently driven.
- `busy`  out  1: high outside IDLE.
- `done`  out  1: one-cycle pulse when the sequence completes.

## Operation
- States: IDLE, LOAD, RUN, WAIT_ZC.
- IDLE:
  - Outputs are `freq`=0, `waveform_sel`=0, `entry`=0, `busy`=0.
  - `start`=1 sets the index to 0 and moves to LOAD.
- LOAD:
  - Registers table[index] into `freq`, `waveform_sel` and the dwell counter (dwell 0 is loaded as 1).
  - Sets `entry`=index and moves to RUN.
- RUN:
  - Decrements the dwell counter each cycle.
  - When the counter equals 1, moves to WAIT_ZC.
- WAIT_ZC:
  - Waits for a rising zero crossing: previous `sample` MSB=1 and current MSB=0.
  - If the current entry has `freq`=0, exits immediately with no crossing required.
  - On exit with index < `cfg_last`: index+1 and go to LOAD.
  - On exit with index == `cfg_last`: handled per Configuration.
- `stop`=1 in any state forces IDLE at the next edge and clears outputs to the IDLE values; `done` is not pulsed.
  - `stop` and `start` asserted together: `stop` wins.
- `start` outside IDLE is ignored.
- `cfg_we` is accepted in every state, one entry per cycle.
  - A write to the entry currently driven does not change the outputs until that entry is next loaded.
  - A write and a LOAD to the same address in the same cycle: LOAD reads the old contents.
- `cfg_last` is sampled only when the index is compared; changing it mid-run takes effect at the next comparison.
- Zero-crossing history register resets to 0, i.e. the previous sample is treated as non-negative.

## Timing
- All outputs and the table reset asynchronously to 0. State resets to IDLE.
- `start` seen at edge k:
  - `busy`=1 after k.
  - Entry 0 appears on `freq`/`waveform_sel` after edge k+1.
- A dwell of D keeps the state in RUN for max(D,1) cycles.
- From the crossing edge c: the next entry's outputs change after edge c+1.
- Minimum per-entry period is 3 cycles: LOAD, RUN, WAIT_ZC with `freq`=0.
- `done` is high for exactly the cycle after the final WAIT_ZC exit; `busy` is 0 in that same cycle.

## Configuration
- `WAVE_SEQ_LOOP_EN` defined:
  - After the last entry, the index wraps to 0 and the state goes to LOAD.
  - `done` never pulses; only `stop` ends the sequence.
- `WAVE_SEQ_LOOP_EN` undefined:
  - After the last entry: pulse `done`, go to IDLE, clear outputs.

## Structure
- Package `wave_seq_pkg` holds:
  - The state enum.
  - Waveform-select constants: SEL_SINE=0, SEL_COS=1, SEL_TRI=2, SEL_SQR=3.
  - Field offsets/widths of the `cfg_wdata` packing.
- Sub-module `wave_seq_zc_det`: registers the sample MSB and outputs the single-cycle `zc` rising-crossing flag.
  - Parameter: `width`.
  - Ports: `clock`, `resetn`, `sample`, `zc`.
- The table is a flop array inside `wave_sequencer`; no RAM macro.

## Test plan
- **Reset:**
  - Stimulus: `resetn`=0 mid-RUN.
  - Response: `freq`=0, `waveform_sel`=0, `busy`=0 immediately (asynchronously); IDLE after release.
- **Two-entry one-shot (macro off):**
  - Stimulus: entry0={0,100,10}, entry1={2,200,5}, `cfg_last`=1, `start`; `sample` crosses -1→0 20 cycles after `start`.
  - Response: `freq`=100 from cycle 2; `freq`=200, `waveform_sel`=2 one cycle after the crossing.
  - Response: `done` pulses once after entry1's first crossing once its dwell expires.
- **No crossing:**
  - Stimulus: `sample` held at -5 after the dwell expires.
  - Response: the state stays in WAIT_ZC indefinitely and `freq` is unchanged.
  - Stimulus: then assert `stop`.
  - Response: IDLE next cycle, `done`=0.
- **freq=0 entry:**
  - Stimulus: entry0={3,0,4}, `cfg_last`=0.
  - Response: `done` pulses 6 cycles after the `start` edge (LOAD, 4 RUN, WAIT_ZC), with no crossing needed.
- **Loop (macro on):**
  - Stimulus: `cfg_last`=1, with crossings supplied.
  - Response: `entry` sequence 0,1,0,1; `done` stays 0; `busy` stays 1.
- **Simultaneous events:**
  - Stimulus: `start` and `stop` together in IDLE.
  - Response: the block remains IDLE.
  - Stimulus: `cfg_we` to the active entry during RUN.
  - Response: outputs unchanged until that entry is reloaded.
